// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, bus FSM state type, pin-count limit and
// byte-lane helper shared by the GPIO bank and its bench.
package gpio_pkg;

    localparam int NPINS_MAX = 32;

    localparam logic [7:0] OFF_OUT      = 8'h00;
    localparam logic [7:0] OFF_OEB      = 8'h04;
    localparam logic [7:0] OFF_IN       = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h10;
    localparam logic [7:0] OFF_IRQ_EDGE = 8'h14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    // Expand the four Wishbone byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: one pad's two-flop synchronizer plus an optional delay flop
// that turns the synchronized level into single-cycle rise/fall pulses.
// With EDGE_DETECT = 0 the delay flop is not built and both pulses are 0.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stable;

    // Two flops in series to settle the asynchronous pad before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= pad;
            stable <= meta;
        end
    end

    assign level = stable;

    generate
        if (EDGE_DETECT) begin : g_edge
            logic delayed;

            // Previous synchronized level; compared with the current one to find edges.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    delayed <= 1'b0;
                end else begin
                    delayed <= stable;
                end
            end

            assign rise = stable & ~delayed;
            assign fall = ~stable & delayed;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone-slave GPIO bank with output, direction and input
// registers. Define GPIO_IRQ_EN to build the edge-triggered interrupt block
// (IRQ_EN / IRQ_STAT / IRQ_EDGE); without it those registers read 0 and irq
// is tied low while the port list stays the same.
module wb_gpio_bank
    import gpio_pkg::*;
#(
    parameter int          NPINS    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oeb,
    output logic             irq
);

`ifdef GPIO_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    bus_state_t       state;
    logic [NPINS-1:0] out_reg;
    logic [NPINS-1:0] oeb_reg;
    logic [NPINS-1:0] in_sync;
    logic [NPINS-1:0] rise_vec;
    logic [NPINS-1:0] fall_vec;
    logic [NPINS-1:0] wr_mask;
    logic [NPINS-1:0] wr_data;
    logic [31:0]      lane_bits;
    logic [31:0]      read_data;
    logic [7:0]       offset;
    logic             selected;
    logic             wr_stb;
    logic             unused_upper;

    assign offset    = wbs_adr_i[7:0];
    assign selected  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr_stb    = (state == ST_IDLE) && selected && wbs_we_i;
    assign lane_bits = lane_mask(wbs_sel_i);
    assign wr_mask   = lane_bits[NPINS-1:0];
    assign wr_data   = wbs_dat_i[NPINS-1:0];

    // Bus bits above the pin count carry nothing for this bank.
    assign unused_upper = ^{lane_bits, wbs_dat_i};

    generate
        for (genvar i = 0; i < NPINS; i++) begin : g_pin
            gpio_sync #(
                .EDGE_DETECT(IRQ_BUILD)
            ) u_sync (
                .clk   (wb_clk_i),
                .rst_n (wb_rst_ni),
                .pad   (gpio_in[i]),
                .level (in_sync[i]),
                .rise  (rise_vec[i]),
                .fall  (fall_vec[i])
            );
        end
    endgenerate

`ifdef GPIO_IRQ_EN
    logic [NPINS-1:0] irq_en_reg;
    logic [NPINS-1:0] irq_stat_reg;
    logic [NPINS-1:0] irq_edge_reg;
    logic [NPINS-1:0] edge_hit;
    logic [NPINS-1:0] stat_clear;

    assign edge_hit   = (rise_vec & ~irq_edge_reg) | (fall_vec & irq_edge_reg);
    assign stat_clear = (wr_stb && (offset == OFF_IRQ_STAT)) ? (wr_data & wr_mask) : '0;

    // Interrupt registers: a new edge always beats a same-cycle W1C clear.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_en_reg   <= '0;
            irq_stat_reg <= '0;
            irq_edge_reg <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_stb && (offset == OFF_IRQ_EN)) begin
                irq_en_reg <= (irq_en_reg & ~wr_mask) | (wr_data & wr_mask);
            end
            if (wr_stb && (offset == OFF_IRQ_EDGE)) begin
                irq_edge_reg <= (irq_edge_reg & ~wr_mask) | (wr_data & wr_mask);
            end
            irq_stat_reg <= (irq_stat_reg & ~stat_clear) | edge_hit;
            irq          <= |(irq_stat_reg & irq_en_reg);
        end
    end
`else
    logic unused_edges;

    assign unused_edges = ^{rise_vec, fall_vec};
    assign irq          = 1'b0;
`endif

    // Read multiplexer; unmapped offsets and absent registers return 0.
    always_comb begin
        read_data = '0;
        case (offset)
            OFF_OUT:      read_data[NPINS-1:0] = out_reg;
            OFF_OEB:      read_data[NPINS-1:0] = oeb_reg;
            OFF_IN:       read_data[NPINS-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
            OFF_IRQ_EN:   read_data[NPINS-1:0] = irq_en_reg;
            OFF_IRQ_STAT: read_data[NPINS-1:0] = irq_stat_reg;
            OFF_IRQ_EDGE: read_data[NPINS-1:0] = irq_edge_reg;
`endif
            default:      read_data = '0;
        endcase
    end

    // Bus FSM: one-cycle ack after a selected cycle, then a mandatory idle cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (selected) begin
                        state     <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= read_data;
                    end else begin
                        wbs_ack_o <= 1'b0;
                        wbs_dat_o <= '0;
                    end
                end
                ST_ACK: begin
                    state     <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
            endcase
        end
    end

    // Output and direction registers, written on the ack edge per byte lane.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            out_reg <= '0;
            oeb_reg <= '1;
        end else if (wr_stb) begin
            case (offset)
                OFF_OUT: out_reg <= (out_reg & ~wr_mask) | (wr_data & wr_mask);
                OFF_OEB: oeb_reg <= (oeb_reg & ~wr_mask) | (wr_data & wr_mask);
                default: ;
            endcase
        end
    end

    assign gpio_out = out_reg;
    assign gpio_oeb = oeb_reg;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb_wb_gpio_bank: randomized self-checking bench for wb_gpio_bank (16 pins).
// Expected values come from a register-level model of the bank kept here.
`timescale 1ns/1ps
module tb_wb_gpio_bank;

    localparam int          NPINS = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_ni = 1'b0;
    logic             wbs_cyc_i = 1'b0;
    logic             wbs_stb_i = 1'b0;
    logic             wbs_we_i = 1'b0;
    logic [3:0]       wbs_sel_i = 4'h0;
    logic [31:0]      wbs_adr_i = 32'h0;
    logic [31:0]      wbs_dat_i = 32'h0;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [NPINS-1:0] gpio_in = '0;
    logic [NPINS-1:0] gpio_out;
    logic [NPINS-1:0] gpio_oeb;
    logic             irq;

    int vectors     = 0;
    int miscompares = 0;

    // Register-level model of the bank
    logic [15:0] m_out, m_oeb, m_en, m_stat, m_edge, m_pins;

    wb_gpio_bank #(
        .NPINS    (NPINS),
        .BASE_ADR (BASE)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] lanes16(input logic [3:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

    task automatic model_reset();
        m_out  = 16'h0000;
        m_oeb  = 16'hFFFF;
        m_en   = 16'h0000;
        m_stat = 16'h0000;
        m_edge = 16'h0000;
    endtask

    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [15:0] m;
        logic [15:0] v;
        m = lanes16(sel);
        v = d[15:0] & m;
        case (off)
            8'h00: m_out = (m_out & ~m) | v;
            8'h04: m_oeb = (m_oeb & ~m) | v;
            8'h0C: if (IRQ_ON) m_en = (m_en & ~m) | v;
            8'h10: if (IRQ_ON) m_stat = m_stat & ~v;
            8'h14: if (IRQ_ON) m_edge = (m_edge & ~m) | v;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return {16'h0, m_out};
            8'h04: return {16'h0, m_oeb};
            8'h08: return {16'h0, m_pins};
            8'h0C: return IRQ_ON ? {16'h0, m_en} : 32'h0;
            8'h10: return IRQ_ON ? {16'h0, m_stat} : 32'h0;
            8'h14: return IRQ_ON ? {16'h0, m_edge} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return IRQ_ON && ((m_stat & m_en) != 16'h0);
    endfunction

    task automatic model_pins(input logic [15:0] pins_new);
        logic [15:0] rising;
        logic [15:0] falling;
        rising  = ~m_pins & pins_new;
        falling = m_pins & ~pins_new;
        if (IRQ_ON) m_stat = m_stat | (rising & ~m_edge) | (falling & m_edge);
        m_pins = pins_new;
    endtask

    task automatic apply_pins(input logic [15:0] pins_new);
        model_pins(pins_new);
        gpio_in = pins_new;
        repeat (5) begin @(posedge wb_clk_i); #1; end
    endtask

    // ---------------- bus driver ----------------
    // Starts a transfer now (just after a rising edge), returns the ack latency
    // (-1 if none within 4 cycles), read data, and ack/data one cycle later.
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel, output logic [31:0] rdat, output int lat,
                            output logic idle_ack, output logic [31:0] idle_dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_sel_i = sel;
        lat = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o && lat == 0) lat = c;
            if (lat != 0) break;
        end
        if (lat == 0) lat = -1;
        rdat      = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
        idle_ack = wbs_ack_o;
        idle_dat = wbs_dat_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        wb_rst_ni = 1'b0;
        gpio_in   = '0;
        m_pins    = 16'h0;
        repeat (3) begin @(posedge wb_clk_i); #1; end
        wb_rst_ni = 1'b1;
        model_reset();
        vectors++;
        if ({wbs_ack_o, wbs_dat_o, irq} !== 34'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ack=%b dat=%h irq=%b required 0/0/0", wbs_ack_o, wbs_dat_o, irq);
        end
        vectors++;
        if (gpio_oeb !== 16'hFFFF || gpio_out !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_pads: got oeb=%h out=%h required FFFF/0000", gpio_oeb, gpio_out);
        end
        bus_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0000_FFFF || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL reset_oeb_read: got %h lat=%0d required 0000FFFF lat=1", rd, lat);
        end
        bus_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0 || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL reset_out_read: got %h lat=%0d required 00000000 lat=1", rd, lat);
        end
    endtask

    task automatic test_out_bytes();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        bus_xfer(1'b1, BASE + 32'h00, 32'h0000_A5A5, 4'b0001, rd, lat, iack, idat);
        model_write(8'h00, 32'h0000_A5A5, 4'b0001);
        vectors++;
        if (gpio_out !== 16'h00A5 || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL out_lane0_pad: got %h lat=%0d required 00A5 lat=1", gpio_out, lat);
        end
        vectors++;
        if (iack !== 1'b0 || idat !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_ack: got ack=%b dat=%h required 0/0", iack, idat);
        end
        bus_xfer(1'b1, BASE + 32'h00, 32'hFFFF_5A3C, 4'b0010, rd, lat, iack, idat);
        model_write(8'h00, 32'hFFFF_5A3C, 4'b0010);
        bus_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== model_read(8'h00)) begin
            miscompares++;
            $display("[TB] FAIL out_lane1_read: got %h required %h", rd, model_read(8'h00));
        end
    endtask

    task automatic test_input_sync();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        apply_pins(16'h0000);
        model_pins(16'h0008);
        gpio_in = 16'h0008;
        @(posedge wb_clk_i); #1;
        bus_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL in_too_early: got %h required 00000000", rd);
        end
        bus_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0000_0008) begin
            miscompares++;
            $display("[TB] FAIL in_after_sync: got %h required 00000008", rd);
        end
        repeat (3) begin @(posedge wb_clk_i); #1; end
    endtask

    task automatic test_unmapped_and_ack();
        logic [31:0] rd, idat;
        logic [3:0]  pattern;
        logic        dat_bad;
        int lat;
        logic iack;
        bus_xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0 || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL unmapped_read: got %h lat=%0d required 00000000 lat=1", rd, lat);
        end
        bus_xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, rd, lat, iack, idat);
        bus_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== model_read(8'h00) || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL unmapped_write_ignored: got %h lat=%0d required %h lat=1", rd, lat, model_read(8'h00));
        end
        bus_xfer(1'b1, 32'h3000_0100, 32'hFFFF_FFFF, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (lat != -1 || gpio_out !== m_out) begin
            miscompares++;
            $display("[TB] FAIL foreign_base: got lat=%0d out=%h required lat=-1 out=%h", lat, gpio_out, m_out);
        end
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE + 32'h40;
        wbs_sel_i = 4'hF;
        pattern[3] = wbs_ack_o;
        dat_bad = 1'b0;
        for (int c = 2; c >= 0; c--) begin
            @(posedge wb_clk_i); #1;
            pattern[c] = wbs_ack_o;
            if (wbs_dat_o !== 32'h0) dat_bad = 1'b1;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;
        vectors++;
        if (pattern !== 4'b0101 || dat_bad) begin
            miscompares++;
            $display("[TB] FAIL ack_pattern: got %b dat_nonzero=%b required 0101 dat_nonzero=0", pattern, dat_bad);
        end
    endtask

    task automatic test_random_regs();
        logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'h18};
        logic [31:0] rd, idat, wd, exp;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic        we;
        int lat;
        logic iack;
        for (int n = 0; n < 40; n++) begin
            if (n % 6 == 5) apply_pins(16'($urandom));
            off = offs[$urandom_range(0, 7)];
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            sel = 4'($urandom_range(0, 15));
            exp = model_read(off);
            bus_xfer(we, BASE + {24'h0, off}, wd, sel, rd, lat, iack, idat);
            if (we) model_write(off, wd, sel);
            vectors++;
            if ((!we && rd !== exp) || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL rand_xfer[%0d] off=%h we=%b: got %h lat=%0d required %h lat=1", n, off, we, rd, lat, exp);
            end
            vectors++;
            if (gpio_out !== m_out || gpio_oeb !== m_oeb || irq !== model_irq()) begin
                miscompares++;
                $display("[TB] FAIL rand_state[%0d]: got out=%h oeb=%h irq=%b required %h %h %b", n, gpio_out, gpio_oeb, irq, m_out, m_oeb, model_irq());
            end
        end
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        apply_pins(16'h0000);
        bus_xfer(1'b1, BASE + 32'h14, 32'h0, 4'hF, rd, lat, iack, idat);
        model_write(8'h14, 32'h0, 4'hF);
        bus_xfer(1'b1, BASE + 32'h0C, 32'h8, 4'hF, rd, lat, iack, idat);
        model_write(8'h0C, 32'h8, 4'hF);
        bus_xfer(1'b1, BASE + 32'h10, 32'hFFFF, 4'hF, rd, lat, iack, idat);
        model_write(8'h10, 32'hFFFF, 4'hF);
        @(posedge wb_clk_i); #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_cleared: got %b required 0", irq);
        end
        apply_pins(16'h0008);
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h8 || irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_rise: got stat=%h irq=%b required 00000008/1", rd, irq);
        end
        bus_xfer(1'b1, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        bus_xfer(1'b1, BASE + 32'h10, 32'hFFFF, 4'h0, rd, lat, iack, idat);
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL w1c_noop: got %h required 00000008", rd);
        end
        bus_xfer(1'b1, BASE + 32'h10, 32'h8, 4'b0001, rd, lat, iack, idat);
        model_write(8'h10, 32'h8, 4'b0001);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL w1c_clear_irq: got %b required 0", irq);
        end
        bus_xfer(1'b1, BASE + 32'h14, 32'h8, 4'hF, rd, lat, iack, idat);
        model_write(8'h14, 32'h8, 4'hF);
        apply_pins(16'h0000);
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== model_read(8'h10) || irq !== model_irq()) begin
            miscompares++;
            $display("[TB] FAIL irq_fall: got stat=%h irq=%b required %h/%b", rd, irq, model_read(8'h10), model_irq());
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        bus_xfer(1'b1, BASE + 32'h14, 32'h0, 4'hF, rd, lat, iack, idat);
        model_write(8'h14, 32'h0, 4'hF);
        model_pins(16'h0008);
        gpio_in = 16'h0008;
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        bus_xfer(1'b1, BASE + 32'h10, 32'h8, 4'hF, rd, lat, iack, idat);
        model_write(8'h10, 32'h8, 4'hF);
        m_stat = m_stat | 16'h0008;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL set_wins_irq: got %b required 1", irq);
        end
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== model_read(8'h10) || irq !== model_irq()) begin
            miscompares++;
            $display("[TB] FAIL set_wins_stat: got stat=%h irq=%b required %h/%b", rd, irq, model_read(8'h10), model_irq());
        end
    endtask
`else
    task automatic test_irq_disabled();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        apply_pins(m_pins ^ 16'h0001);
        apply_pins(m_pins ^ 16'h0001);
        bus_xfer(1'b1, BASE + 32'h0C, 32'hFFFF, 4'hF, rd, lat, iack, idat);
        bus_xfer(1'b1, BASE + 32'h14, 32'hFFFF, 4'hF, rd, lat, iack, idat);
        bus_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL noirq_en: got en=%h irq=%b required 00000000/0", rd, irq);
        end
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL noirq_stat: got %h required 00000000", rd);
        end
        bus_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL noirq_edge: got edge=%h irq=%b required 00000000/0", rd, irq);
        end
    endtask
`endif

    task automatic test_reset_mid_transfer();
        logic [31:0] rd, idat;
        int lat;
        logic iack;
        apply_pins(16'h0000);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE + 32'h00;
        wbs_dat_i = 32'hFFFF_FFFF;
        wbs_sel_i = 4'hF;
        wb_rst_ni = 1'b0;
        @(posedge wb_clk_i); #1;
        vectors++;
        if (wbs_ack_o !== 1'b0 || irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort_ack: got ack=%b irq=%b required 0/0", wbs_ack_o, irq);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wb_rst_ni = 1'b1;
        model_reset();
        @(posedge wb_clk_i); #1;
        vectors++;
        if (wbs_ack_o !== 1'b0 || gpio_out !== 16'h0 || gpio_oeb !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_abort_state: got ack=%b out=%h oeb=%h required 0/0000/FFFF", wbs_ack_o, gpio_out, gpio_oeb);
        end
        bus_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== model_read(8'h00) || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL reset_abort_out: got %h lat=%0d required %h lat=1", rd, lat, model_read(8'h00));
        end
        bus_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, iack, idat);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort_stat: got %h required 00000000", rd);
        end
    endtask

    initial begin
        m_pins = 16'h0;
        model_reset();
        test_reset();
        test_out_bytes();
        test_input_sync();
        test_unmapped_and_ack();
        test_random_regs();
`ifdef GPIO_IRQ_EN
        test_irq();
        test_set_wins();
`else
        test_irq_disabled();
`endif
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_gpio_bank.md
WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

Interface
REQ-001 SHALL have parameter NPINS, default 16, number of GPIO pins (legal 1..32).
REQ-002 SHALL have parameter BASE_ADR, default 32'h3000_0000, Wishbone base address; decode on wbs_adr_i[31:8] == BASE_ADR[31:8].
REQ-003 SHALL have the following ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  synchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave control.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- gpio_in  in  NPINS  pad inputs, asynchronous.
- gpio_out  out  NPINS  pad outputs.
- gpio_oeb  out  NPINS  pad direction, 1 = input, 0 = output.
- irq  out  1  level interrupt.

Function
REQ-004 SHALL use register map (offset from BASE_ADR): 0x00 OUT (RW), 0x04 OEB (RW), 0x08 IN (RO), 0x0C IRQ_EN (RW), 0x10 IRQ_STAT (RW1C), 0x14 IRQ_EDGE (RW; 0 = rising, 1 = falling).
REQ-005 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after a selected cyc&stb is first seen; ack SHALL be low in the following cycle even if stb stays high, so back-to-back transfers complete at most every 2 cycles.
REQ-006 Writes SHALL take effect on the ack edge, byte lanes gated by wbs_sel_i; bits [31:NPINS] SHALL be ignored on write and read as 0.
REQ-007 wbs_dat_o SHALL be valid while wbs_ack_o is high and 0 otherwise; unmapped offsets SHALL ack, read 0, and ignore writes.
REQ-008 gpio_out SHALL equal OUT and gpio_oeb SHALL equal OEB, both registered, with no combinational path from the bus.
REQ-009 IN SHALL be gpio_in through a 2-flop synchronizer; a pad change becomes visible in IN 2 cycles later.
REQ-010 An edge SHALL be detected by comparing the synchronized value with its 1-cycle-delayed copy, selecting polarity per bit from IRQ_EDGE.
REQ-011 A detected edge SHALL set the IRQ_STAT bit whether or not IRQ_EN is set; irq = |(IRQ_STAT & IRQ_EN), registered.
REQ-012 On a simultaneous W1C clear and new edge on the same bit, the set SHALL win.
REQ-013 Writing 0 to a IRQ_STAT bit SHALL have no effect; a write to IRQ_STAT with wbs_sel_i = 0 SHALL change nothing.
REQ-014 Bus behaviour SHALL be a two-state FSM, IDLE -> ACK on selected cyc&stb, ACK -> IDLE unconditionally; dropping cyc in IDLE SHALL produce no ack.

Reset
REQ-015 While wb_rst_ni is low at a clock edge: OUT = 0, OEB = all ones (all inputs), IRQ_EN = 0, IRQ_STAT = 0, IRQ_EDGE = 0, synchronizers = 0, FSM = IDLE, wbs_ack_o = 0, wbs_dat_o = 0, irq = 0.
REQ-016 Reset asserted mid-transfer SHALL abort it without an ack; the first cycle after release SHALL NOT flag an edge.

Configuration
REQ-017 With macro GPIO_IRQ_EN defined, REQ-010..REQ-013 SHALL be implemented as written.
REQ-018 Without GPIO_IRQ_EN, IRQ_EN, IRQ_STAT and IRQ_EDGE SHALL read 0 and ignore writes, the edge logic SHALL be absent, and irq SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-019 Package gpio_pkg SHALL hold the register offset constants, the FSM state typedef, and the NPINS maximum (32).
REQ-020 Sub-module gpio_sync SHALL hold one pin's 2-flop synchronizer and delay flop, and output the synchronized level plus rise and fall pulses; it is instantiated NPINS times via generate.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then read OEB and OUT -> OEB = 0x0000FFFF, OUT = 0x0; gpio_oeb = 16'hFFFF.
- Write OUT = 0xA5A5 with sel = 4'b0001 -> OUT = 0x00A5; gpio_out = 16'h00A5 in the cycle after ack.
- gpio_in[3] 0->1 -> IN[3] = 1 two cycles later; with IRQ_EN[3] = 1, IRQ_STAT = 0x8 and irq = 1.
- Write IRQ_STAT = 0x8 in the same cycle a new rising edge on pin 3 is detected -> IRQ_STAT stays 0x8 and irq stays 1.
- Read offset 0x40 -> ack after 1 cycle, data 0; cyc&stb held high for 4 cycles -> ack pattern 0,1,0,1.
- Built without GPIO_IRQ_EN, toggle gpio_in[0] and write IRQ_EN = 0xFFFF -> IRQ_EN reads 0 and irq stays 0.
